uart_tx_param: RTL and testbench

Parametrised UART transmitter that serialises one data word per frame onto `txd`. It supports configurable data width, optional odd/even parity, 1 or 2 stop bits and an integer clock-per-bit divisor. It takes words through a valid/ready handshake and is gated by `connection_status`. It sits between the byte-producing logic and the UART pin, alongside the existing receive side of the UART interface controller.

---
 rtl/uart_tx_param.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param -- parametrised UART transmitter.
//
// Serialises one DATA_BITS word per frame onto txd: start bit (0), data bits
// LSB first, optional parity bit, then STOP_BITS stop bits (1). Words are
// taken through a valid/ready handshake, and new frames are accepted only
// while connection_status is high. A frame already in flight always runs to
// completion unless rst aborts it.
//
// Parameters
//   DATA_BITS     data bits per frame (5..9)
//   CLKS_PER_BIT  clk cycles per bit period (>= 2)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports
//   clk                in   system clock, rising edge
//   rst                in   synchronous active-high reset
//   connection_status  in   1 = link up, frames may be accepted
//   data               in   word to send, sampled on acceptance
//   valid              in   data is valid
//   ready              out  block can accept a word this cycle (combinational)
//   txd                out  serial line, idle high (registered)
//   busy               out  frame in progress (registered)
module uart_tx_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 connection_status,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  // The final cycle of the last stop bit is spent in IDLE (txd is 1 there
  // anyway), so a waiting word can be accepted on the edge that ends the
  // frame and the next start bit follows with no gap.
  localparam logic [TW-1:0] TIMER_HAND = TW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;

  logic bit_end;
  logic accept;

  assign bit_end = (timer_q == TIMER_LAST);
  assign ready   = (state_q == IDLE) && connection_status && !rst;
  assign accept  = valid && ready;
  assign txd     = txd_q;
  assign busy    = busy_q;

  // NOTE: every _d gets a default before the case so no path leaves a
  // signal unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    timer_d = bit_end ? '0 : timer_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    stop_d  = stop_q;
    txd_d   = txd_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          state_d = START;
          shreg_d = data;
          par_d   = (PARITY == 1) ? ~^data : ^data;
          idx_d   = '0;
          stop_d  = 1'b0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shreg_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY != 0) begin
              state_d = PAR;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
          end
        end
      end

      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end

      STOP: begin
        txd_d = 1'b1;
        if (stop_q == STOP_LAST && timer_q == TIMER_HAND) begin
          // busy stays high through the handover cycle spent in IDLE.
          state_d = IDLE;
          timer_d = '0;
        end else if (bit_end) begin
          stop_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param. Four instances cover 8N1, 8E1, 8O1
// (all CLKS_PER_BIT=4) and 7N2 (CLKS_PER_BIT=3). Expected line levels come
// from a frame-level model: the list of bit values a frame must carry, each
// held CLKS_PER_BIT cycles.
module tb_uart_tx_param;

  localparam int CFG_W   [4] = '{8, 8, 8, 7};
  localparam int CFG_CPB [4] = '{4, 4, 4, 3};
  localparam int CFG_PAR [4] = '{0, 2, 1, 0};
  localparam int CFG_STOP[4] = '{1, 1, 1, 2};

  logic       clk;
  logic       rst;
  logic       conn;
  logic [8:0] data_s  [4];
  logic       valid_s [4];
  logic       ready_s [4];
  logic       txd_s   [4];
  logic       busy_s  [4];

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .connection_status(conn), .data(data_s[0][7:0]),
    .valid(valid_s[0]), .ready(ready_s[0]), .txd(txd_s[0]), .busy(busy_s[0]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .connection_status(conn), .data(data_s[1][7:0]),
    .valid(valid_s[1]), .ready(ready_s[1]), .txd(txd_s[1]), .busy(busy_s[1]));

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .connection_status(conn), .data(data_s[2][7:0]),
    .valid(valid_s[2]), .ready(ready_s[2]), .txd(txd_s[2]), .busy(busy_s[2]));

  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(3), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .connection_status(conn), .data(data_s[3][6:0]),
    .valid(valid_s[3]), .ready(ready_s[3]), .txd(txd_s[3]), .busy(busy_s[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int frame_bits(input int d);
    return 1 + CFG_W[d] + ((CFG_PAR[d] != 0) ? 1 : 0) + CFG_STOP[d];
  endfunction

  function automatic int frame_cycles(input int d);
    return frame_bits(d) * CFG_CPB[d];
  endfunction

  // Value of bit b (0 = start) of the frame carrying word on instance d.
  function automatic logic exp_bit(input int d, input int word, input int b);
    int w;
    int ones;
    w = CFG_W[d];
    if (b == 0) return 1'b0;
    if (b <= w) return logic'((word >> (b - 1)) & 1);
    if (CFG_PAR[d] != 0 && b == w + 1) begin
      ones = $countones(word & ((1 << w) - 1));
      if (CFG_PAR[d] == 2) return logic'(ones % 2);
      return logic'(1 - (ones % 2));
    end
    return 1'b1;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Present word and wait (bounded) until the next edge accepts it. Returns
  // just after that accepting edge.
  task automatic start_word(input int d, input int word, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    data_s[d]  = 9'(word);
    valid_s[d] = 1'b1;
    #1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (ready_s[d] === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    n_checks++;
    if (!ok) $display("FAIL accept_timeout dut%0d: ready never rose (got %b, required 1)", d, ready_s[d]);
    else n_pass++;
    @(posedge clk);
  endtask

  // Walk ncyc cycles of a frame that was accepted on the previous edge,
  // checking txd against the model and busy high. On cycle 0 valid/data are
  // changed (next word for back-to-back, or junk that must be ignored).
  task automatic frame_check(input int d, input int word, input bit next_valid,
                             input int next_word, input int drop_at, input int ncyc);
    logic e;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        valid_s[d] = next_valid;
        data_s[d]  = next_valid ? 9'(next_word) : 9'($urandom);
      end
      if (c == drop_at) conn = 1'b0;
      e = exp_bit(d, word, c / CFG_CPB[d]);
      n_checks++;
      if (txd_s[d] !== e)
        $display("FAIL txd dut%0d word=%h cycle %0d: got %b, required %b", d, word, c, txd_s[d], e);
      else n_pass++;
      n_checks++;
      if (busy_s[d] !== 1'b1)
        $display("FAIL busy_high dut%0d word=%h cycle %0d: got %b, required 1", d, word, c, busy_s[d]);
      else n_pass++;
    end
  endtask

  task automatic idle_check(input int d, input logic exp_ready);
    @(negedge clk);
    #1;
    n_checks++;
    if (busy_s[d] !== 1'b0) $display("FAIL busy_end dut%0d: got %b, required 0", d, busy_s[d]);
    else n_pass++;
    n_checks++;
    if (txd_s[d] !== 1'b1) $display("FAIL txd_idle dut%0d: got %b, required 1", d, txd_s[d]);
    else n_pass++;
    n_checks++;
    if (ready_s[d] !== exp_ready)
      $display("FAIL ready_end dut%0d: got %b, required %b", d, ready_s[d], exp_ready);
    else n_pass++;
  endtask

  task automatic send(input int d, input int word);
    bit ok;
    start_word(d, word, ok);
    if (ok) begin
      frame_check(d, word, 1'b0, 0, -1, frame_cycles(d));
      idle_check(d, 1'b1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst  = 1'b1;
    conn = 1'b1;
    for (int d = 0; d < 4; d++) begin
      valid_s[d] = 1'b0;
      data_s[d]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (txd_s[d] !== 1'b1 || busy_s[d] !== 1'b0 || ready_s[d] !== 1'b0)
        $display("FAIL reset_state dut%0d: txd/busy/ready got %b%b%b, required 100",
                 d, txd_s[d], busy_s[d], ready_s[d]);
      else n_pass++;
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (ready_s[d] !== 1'b1) $display("FAIL ready_after_reset dut%0d: got %b, required 1", d, ready_s[d]);
      else n_pass++;
    end
  endtask

  task automatic test_8n1;
    send(0, 'h81);
  endtask

  task automatic test_parity;
    send(1, 'h81);
    send(2, 'h81);
    send(1, 'h07);
    send(2, 'h07);
  endtask

  task automatic test_7n2;
    send(3, 'h41);
  endtask

  task automatic test_random;
    int w;
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 6; k++) begin
        w = int'($urandom_range(0, (1 << CFG_W[d]) - 1));
        send(d, w);
      end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int a;
    int b;
    start_word(0, 'h55, ok);
    if (ok) begin
      frame_check(0, 'h55, 1'b1, 'hAA, -1, frame_cycles(0));
      frame_check(0, 'hAA, 1'b0, 0, -1, frame_cycles(0));
      idle_check(0, 1'b1);
    end
    a = int'($urandom_range(0, 127));
    b = int'($urandom_range(0, 127));
    start_word(3, a, ok);
    if (ok) begin
      frame_check(3, a, 1'b1, b, -1, frame_cycles(3));
      frame_check(3, b, 1'b0, 0, -1, frame_cycles(3));
      idle_check(3, 1'b1);
    end
  endtask

  task automatic test_connection;
    int bad;
    bad = 0;
    @(negedge clk);
    conn       = 1'b0;
    data_s[0]  = 9'h3C;
    valid_s[0] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (ready_s[0] !== 1'b0 || txd_s[0] !== 1'b1 || busy_s[0] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL conn_low_hold: %0d bad cycles, required 0", bad);
    else n_pass++;
    @(negedge clk);
    conn = 1'b1;
    #1;
    n_checks++;
    if (ready_s[0] !== 1'b1) $display("FAIL conn_raise_ready: got %b, required 1", ready_s[0]);
    else n_pass++;
    @(posedge clk);
    frame_check(0, 'h3C, 1'b0, 0, 12, frame_cycles(0));
    idle_check(0, 1'b0);
    conn = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int w;
    w = int'($urandom_range(0, 255));
    start_word(0, w, ok);
    if (ok) begin
      frame_check(0, w, 1'b0, 0, -1, 17);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (txd_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || ready_s[0] !== 1'b0)
        $display("FAIL mid_reset: txd/busy/ready got %b%b%b, required 100",
                 txd_s[0], busy_s[0], ready_s[0]);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if (ready_s[0] !== 1'b1) $display("FAIL ready_after_mid_reset: got %b, required 1", ready_s[0]);
      else n_pass++;
    end
    send(0, int'($urandom_range(0, 255)));
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_7n2;
    test_back_to_back;
    test_connection;
    test_reset_mid_frame;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
